// File: rtl/toggle_pulse_decoder_if.sv
// Event-side bundle of the toggle pulse decoder: toggle line and clear in, queued events out.
// The decoder takes the slave modport; the producer/consumer side takes master.
interface toggle_pulse_decoder_if #(
  parameter int CNT_W = 4
);
  logic             tog_in;
  logic             clr;
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             tog_level;

  modport master (
    output tog_in, clr, evt_ready,
    input  evt_valid, pending, overflow, tog_level
  );

  modport slave (
    input  tog_in, clr, evt_ready,
    output evt_valid, pending, overflow, tog_level
  );
endinterface

// File: rtl/toggle_pulse_decoder.sv
// Recovers one event per edge of a toggle-encoded line and queues it in a saturating counter.
// Define TPD_SYNC_EN to insert a 2-stage synchronizer on tog_in (adds 2 edges of latency).
module toggle_pulse_decoder #(
  parameter int   CNT_W      = 4,
  parameter logic INIT_LEVEL = 1'b0
) (
  input logic                   clk,
  input logic                   resetb,
  toggle_pulse_decoder_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             tin_eff;
  logic             s_q;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             det;
  logic             acc;

`ifdef TPD_SYNC_EN
  logic [1:0] sync_q;

  // Both stages start at the reference level so release never fakes an edge.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= {2{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], bus.tog_in};
    end
  end

  assign tin_eff = sync_q[1];
`else
  assign tin_eff = bus.tog_in;
`endif

  assign det = (tin_eff != s_q);
  assign acc = bus.evt_valid & bus.evt_ready;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (det && !acc) begin
      if (pend_q == MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + ONE;
      end
    end else if (!det && acc) begin
      pend_d = pend_q - ONE;
    end
  end

  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      s_q    <= INIT_LEVEL;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= tin_eff;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.evt_valid = (pend_q != '0);
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;
  assign bus.tog_level = s_q;
endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Bench for toggle_pulse_decoder: directed scenarios plus random traffic against an event-count model.
module tb_toggle_pulse_decoder;
  localparam int   CNT_W = 4;
  localparam int   MAXV  = (1 << CNT_W) - 1;
  localparam logic INIT  = 1'b0;
`ifdef TPD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic resetb;
  int   checks = 0;
  int   errors = 0;
  logic tg = 1'b0;

  toggle_pulse_decoder_if #(.CNT_W(CNT_W)) bus ();

  toggle_pulse_decoder #(.CNT_W(CNT_W), .INIT_LEVEL(INIT)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the line level as seen LAT edges late, an event count clamped to [0,MAX], a sticky loss flag.
  int m_pend;
  bit m_ovf;
  bit m_lvl;
  bit dl[$];

  always @(negedge clk or negedge resetb) begin
    if (!resetb) begin
      m_pend = 0;
      m_ovf  = 1'b0;
      m_lvl  = INIT;
      dl.delete();
      for (int i = 0; i < LAT; i++) dl.push_back(INIT);
    end else begin
      bit teff, ev, take;
      dl.push_back(bus.tog_in);
      teff = dl.pop_front();
      ev   = (teff != m_lvl);
      take = (m_pend > 0) && bus.evt_ready;
      m_lvl = teff;
      if (bus.clr) begin
        m_pend = 0;
        m_ovf  = 1'b0;
      end else begin
        m_pend = m_pend + int'(ev) - int'(take);
        if (m_pend > MAXV) begin
          m_pend = MAXV;
          m_ovf  = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (resetb) begin
      chk("pending",   int'(bus.pending),   m_pend);
      chk("evt_valid", int'(bus.evt_valid), int'(m_pend != 0));
      chk("overflow",  int'(bus.overflow),  int'(m_ovf));
      chk("tog_level", int'(bus.tog_level), int'(m_lvl));
    end
  end

  // One falling edge with the given inputs; returns just after the following rising edge.
  task automatic edge_(input logic t, input logic rdy, input logic c);
    bus.tog_in    = t;
    bus.evt_ready = rdy;
    bus.clr       = c;
    tg            = t;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic c);
    for (int i = 0; i < n; i++) edge_(tg, 1'b0, c);
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) edge_(~tg, 1'b0, 1'b0);
    hold(LAT, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    resetb        = 1'b0;
    bus.tog_in    = 1'b0;
    bus.clr       = 1'b0;
    bus.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    bus.tog_in = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pending",   int'(bus.pending),   0);
    chk("rst_valid",     int'(bus.evt_valid), 0);
    chk("rst_overflow",  int'(bus.overflow),  0);
    chk("rst_tog_level", int'(bus.tog_level), int'(INIT));
    bus.tog_in = 1'b0;
    resetb     = 1'b1;

    hold(10, 1'b0);
    chk("t1_pending",  int'(bus.pending),  0);
    chk("t1_overflow", int'(bus.overflow), 0);

    edge_(1'b1, 1'b0, 1'b0);
    edge_(1'b0, 1'b0, 1'b0);
    hold(LAT, 1'b0);
    chk("t2_pending2", int'(bus.pending), 2);
    edge_(tg, 1'b1, 1'b0);
    edge_(tg, 1'b1, 1'b0);
    chk("t2_pending0", int'(bus.pending),   0);
    chk("t2_valid0",   int'(bus.evt_valid), 0);

    toggles(15);
    chk("t3_pend15",  int'(bus.pending),  15);
    chk("t3_ovf_pre", int'(bus.overflow), 0);
    toggles(1);
    chk("t3_pend_sat", int'(bus.pending),  15);
    chk("t3_ovf_set",  int'(bus.overflow), 1);
    edge_(~tg, 1'b1, 1'b0);
    hold(LAT, 1'b0);
    chk("t3_pend_acc", int'(bus.pending),  15);
    chk("t3_ovf_hold", int'(bus.overflow), 1);

    hold(1, 1'b1);
    toggles(3);
    chk("t4_pend3", int'(bus.pending), 3);
    edge_(~tg, 1'b1, 1'b0);
    hold(LAT, 1'b0);
    chk("t4_det_acc", int'(bus.pending), 3);
    edge_(~tg, 1'b0, 1'b1);
    hold(LAT, 1'b1);
    chk("t4_clr_pend",  int'(bus.pending),   0);
    chk("t4_clr_ovf",   int'(bus.overflow),  0);
    chk("t4_tog_level", int'(bus.tog_level), int'(tg));

    edge_(1'b0, 1'b0, 1'b1);
    hold(LAT, 1'b1);
    toggles(5);
    chk("t5_pend5", int'(bus.pending), 5);
    #2 resetb = 1'b0;
    #1;
    chk("t5_async_pend",  int'(bus.pending),   0);
    chk("t5_async_valid", int'(bus.evt_valid), 0);
    bus.tog_in = 1'b1;
    @(posedge clk);
    #1 resetb = 1'b1;
    edge_(1'b1, 1'b0, 1'b0);
    hold(LAT, 1'b0);
    chk("t5_first_edge", int'(bus.pending), 1);

    // Single toggle: the count must appear exactly LAT edges after the edge that first sees it.
    hold(1, 1'b1);
    edge_(~tg, 1'b0, 1'b0);
    chk("t6_edge0", int'(bus.pending), int'(LAT == 0));
    edge_(tg, 1'b0, 1'b0);
    chk("t6_edge1", int'(bus.pending), int'(LAT <= 1));
    edge_(tg, 1'b0, 1'b0);
    chk("t6_edge2", int'(bus.pending), 1);

    for (int i = 0; i < 600; i++) begin
      logic t, r, c;
      t = ($urandom_range(0, 1) == 1) ? ~tg : tg;
      r = ($urandom_range(0, 99) < ((i / 150) % 2 == 0 ? 20 : 70));
      c = ($urandom_range(0, 63) == 0);
      edge_(t, r, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
